conv2d_postproc: RTL and testbench

Streaming post-processing stage placed directly downstream of conv2d. It takes conv2d's widened pixel stream (DATA_W+GAIN_W bits), removes the invalid wrap-around columns, and requantizes each kept sample back to DATA_W bits using round-half-up, a right shift and saturation. It also tracks raster position and emits start-of-frame, end-of-line and end-of-frame markers for the next stage.

---
 rtl/conv_pkg.sv | 50 +++++
 rtl/conv2d_postproc_if.sv | 37 +++
 rtl/conv2d_round_sat.sv | 82 ++++++++
 rtl/conv2d_postproc.sv | 180 ++++++++++++++++++
 tb/tb_conv2d_postproc.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the conv2d post-processing slice.
//   DATA_W / GAIN_W : default widths of the output pixel and of the extra bits
//                     conv2d adds; IN_W is the width of a conv2d output sample.
//   R_W             : width of a sample after the rounding bias is added.
//   round_shift_sat : reference requantisation at the default widths
//                     (round-half-up, right shift, clamp to DATA_W bits).
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int GAIN_W = 4;
    localparam int IN_W   = DATA_W + GAIN_W;
    localparam int R_W    = IN_W + 1;

    localparam logic [R_W-1:0] PIX_MAX = R_W'((2 ** DATA_W) - 1);

    typedef struct packed {
        logic              sat;
        logic [DATA_W-1:0] pix;
    } rsat_t;

    // Adds half an output LSB so the following shift rounds half-up.
    function automatic logic [R_W-1:0] round_add(input logic [IN_W-1:0] value,
                                                 input int unsigned     shift);
        logic [R_W-1:0] bias;
        bias = '0;
        if (shift > 0) begin
            bias = R_W'(1) << (shift - 1);
        end
        return {1'b0, value} + bias;
    endfunction

    function automatic rsat_t shift_sat(input logic [R_W-1:0] r,
                                        input int unsigned    shift);
        logic [R_W-1:0] q;
        rsat_t          res;
        q       = r >> shift;
        res.sat = (q > PIX_MAX);
        res.pix = res.sat ? '1 : q[DATA_W-1:0];
        return res;
    endfunction

    function automatic rsat_t round_shift_sat(input logic [IN_W-1:0] value,
                                              input int unsigned     shift);
        return shift_sat(round_add(value, shift), shift);
    endfunction

endpackage

// File: rtl/conv2d_postproc_if.sv
// -----------------------------------------------------------------------------
// conv2d_postproc_if
// Valid-only stream bundle between conv2d, the post-processor and the next
// stage. No backpressure.
//   valid_in, pixel_in, frame_start      : upstream samples (from conv2d)
//   valid_out, pixel_out                 : requantised downstream samples
//   sof_out, eol_out, eof_out            : raster markers qualified by valid_out
//   sat_count                            : saturation statistics
// Modports: slave = post-processor view, master = source/sink (bench) view.
// -----------------------------------------------------------------------------
interface conv2d_postproc_if #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int GAIN_W = conv_pkg::GAIN_W
);

    logic                       valid_in;
    logic [DATA_W+GAIN_W-1:0]   pixel_in;
    logic                       frame_start;

    logic                       valid_out;
    logic [DATA_W-1:0]          pixel_out;
    logic                       sof_out;
    logic                       eol_out;
    logic                       eof_out;
    logic [15:0]                sat_count;

    modport slave (
        input  valid_in, pixel_in, frame_start,
        output valid_out, pixel_out, sof_out, eol_out, eof_out, sat_count
    );

    modport master (
        output valid_in, pixel_in, frame_start,
        input  valid_out, pixel_out, sof_out, eol_out, eof_out, sat_count
    );

endinterface

// File: rtl/conv2d_round_sat.sv
// -----------------------------------------------------------------------------
// conv2d_round_sat
// Second pipeline stage: shifts an already-rounded sample right by SHIFT and
// clamps it to DATA_W bits, registering the result with its markers.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   i_valid, i_r               : kept sample, rounded value (DATA_W+GAIN_W+1 b)
//   i_sof, i_eol, i_eof        : markers travelling with the sample
//   o_valid, o_pixel           : registered output; pixel holds when idle
//   o_sof, o_eol, o_eof        : registered markers, 0 when o_valid=0
//   o_sat                      : the registered sample was clamped
// -----------------------------------------------------------------------------
module conv2d_round_sat #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int GAIN_W = conv_pkg::GAIN_W,
    parameter int SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic [DATA_W+GAIN_W:0]   i_r,
    input  logic                     i_sof,
    input  logic                     i_eol,
    input  logic                     i_eof,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_pixel,
    output logic                     o_sof,
    output logic                     o_eol,
    output logic                     o_eof,
    output logic                     o_sat
);

    localparam int R_W = DATA_W + GAIN_W + 1;
    localparam logic [R_W-1:0] PIX_MAX = R_W'((2 ** DATA_W) - 1);

    logic [R_W-1:0]    w_q;
    logic              w_sat;
    logic [DATA_W-1:0] w_pix;

    assign w_q   = i_r >> SHIFT;
    assign w_sat = (w_q > PIX_MAX);
    assign w_pix = w_sat ? '1 : w_q[DATA_W-1:0];

    logic              r_valid;
    logic [DATA_W-1:0] r_pixel;
    logic              r_sof;
    logic              r_eol;
    logic              r_eof;
    logic              r_sat;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            // NOTE: the data register is reset too, since downstream logic may
            // look at pixel_out right after reset before any sample arrives.
            r_pixel <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= i_valid;
            r_sof   <= i_valid & i_sof;
            r_eol   <= i_valid & i_eol;
            r_eof   <= i_valid & i_eof;
            r_sat   <= i_valid & w_sat;
            if (i_valid) begin
                r_pixel <= w_pix;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_pixel = r_pixel;
    assign o_sof   = r_sof;
    assign o_eol   = r_eol;
    assign o_eof   = r_eof;
    assign o_sat   = r_sat;

endmodule

// File: rtl/conv2d_postproc.sv
// -----------------------------------------------------------------------------
// conv2d_postproc
// Post-processor behind conv2d: drops the KERNEL_SIZE-1 wrap-around columns of
// every row, requantises kept samples (round-half-up, >> SHIFT, saturate to
// DATA_W) and tags them with start-of-frame / end-of-line / end-of-frame.
// Two-stage pipeline: stage 1 = position tracking, keep decision, rounding
// bias; stage 2 = conv2d_round_sat. Kept valid_in -> valid_out in 2 cycles.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (clears counters and pipeline)
//   bus    : conv2d_postproc_if.slave stream bundle
// Build option:
//   CONV_POSTPROC_SAT_STATS_EN defined -> sat_count counts clamped output
//   pixels per frame (cleared at sof_out, sticks at 0xFFFF); undefined ->
//   sat_count is constant 0.
// -----------------------------------------------------------------------------
module conv2d_postproc #(
    parameter int DATA_W      = conv_pkg::DATA_W,
    parameter int GAIN_W      = conv_pkg::GAIN_W,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    parameter int KERNEL_SIZE = 3,
    parameter int SHIFT       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    conv2d_postproc_if.slave   bus
);

    localparam int R_W   = DATA_W + GAIN_W + 1;
    localparam int ROWS  = IMG_HEIGHT - KERNEL_SIZE + 1;
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] KEEP_FIRST = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    // Half an output LSB; zero when no shift is applied.
    localparam logic [R_W-1:0]   ROUND_BIAS = R_W'((2 ** SHIFT) / 2);

    // ------------------------------------------------------------------
    // Raster position of the sample currently on the input
    // ------------------------------------------------------------------
    logic [COL_W-1:0] r_col_cnt;
    logic [ROW_W-1:0] r_row_cnt;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col_next;
    logic [ROW_W-1:0] w_row_next;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_col = r_col_cnt;
        w_row = r_row_cnt;
        // frame_start forces the accompanying sample to row 0, col 0.
        if (bus.frame_start) begin
            w_col = '0;
            w_row = '0;
        end
        w_col_next = w_col + COL_W'(1);
        w_row_next = w_row;
        if (w_col == COL_LAST) begin
            w_col_next = '0;
            w_row_next = (w_row == ROW_LAST) ? '0 : w_row + ROW_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: keep decision, markers, rounding bias
    // ------------------------------------------------------------------
    logic           w_keep;
    logic           w_sof;
    logic           w_eol;
    logic           w_eof;
    logic [R_W-1:0] w_r;

    assign w_keep = bus.valid_in && (w_col >= KEEP_FIRST);
    assign w_sof  = w_keep && (w_row == '0) && (w_col == KEEP_FIRST);
    assign w_eol  = w_keep && (w_col == COL_LAST);
    assign w_eof  = w_eol && (w_row == ROW_LAST);
    assign w_r    = {1'b0, bus.pixel_in} + ROUND_BIAS;

    logic           r_s1_valid;
    logic [R_W-1:0] r_s1_r;
    logic           r_s1_sof;
    logic           r_s1_eol;
    logic           r_s1_eof;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_r     <= '0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_eof   <= 1'b0;
        end else begin
            r_s1_valid <= w_keep;
            r_s1_sof   <= w_sof;
            r_s1_eol   <= w_eol;
            r_s1_eof   <= w_eof;
            if (w_keep) begin
                r_s1_r <= w_r;
            end
            if (bus.valid_in) begin
                r_col_cnt <= w_col_next;
                r_row_cnt <= w_row_next;
            end else if (bus.frame_start) begin
                // Resync without a sample: the next valid sample is row 0, col 0.
                r_col_cnt <= '0;
                r_row_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shift + saturate
    // ------------------------------------------------------------------
    logic              w_s2_valid;
    logic [DATA_W-1:0] w_s2_pixel;
    logic              w_s2_sof;
    logic              w_s2_eol;
    logic              w_s2_eof;
    logic              w_s2_sat;

    conv2d_round_sat #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W),
        .SHIFT  (SHIFT)
    ) u_round_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_s1_valid),
        .i_r     (r_s1_r),
        .i_sof   (r_s1_sof),
        .i_eol   (r_s1_eol),
        .i_eof   (r_s1_eof),
        .o_valid (w_s2_valid),
        .o_pixel (w_s2_pixel),
        .o_sof   (w_s2_sof),
        .o_eol   (w_s2_eol),
        .o_eof   (w_s2_eof),
        .o_sat   (w_s2_sat)
    );

    assign bus.valid_out = w_s2_valid;
    assign bus.pixel_out = w_s2_pixel;
    assign bus.sof_out   = w_s2_sof;
    assign bus.eol_out   = w_s2_eol;
    assign bus.eof_out   = w_s2_eof;

    // ------------------------------------------------------------------
    // Saturation statistics (updates the cycle after the output pixel)
    // ------------------------------------------------------------------
`ifdef CONV_POSTPROC_SAT_STATS_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (w_s2_valid) begin
            if (w_s2_sof) begin
                // New frame: restart, counting the first pixel's own clamp.
                r_sat_count <= {15'd0, w_s2_sat};
            end else if (w_s2_sat && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
        end
    end

    assign bus.sat_count = r_sat_count;
`else
    logic w_unused_sat;
    assign w_unused_sat  = w_s2_sat;
    assign bus.sat_count = '0;
`endif

endmodule

// File: tb/tb_conv2d_postproc.sv
// -----------------------------------------------------------------------------
// tb_conv2d_postproc
// Directed bench for conv2d_postproc. A SHIFT=4 instance covers full frames,
// rounding, saturation, markers with bubbles, frame_start resync and mid-row
// reset; a SHIFT=0 instance covers the pass-through path.
// -----------------------------------------------------------------------------
module tb_conv2d_postproc;
    import conv_pkg::*;

    localparam int IMG_W  = 64;
    localparam int N_ROWS = 62;
    localparam int KS     = 3;

    logic clk;
    logic rst_n;

    conv2d_postproc_if #(.DATA_W(8), .GAIN_W(4)) bus  ();
    conv2d_postproc_if #(.DATA_W(8), .GAIN_W(4)) bus0 ();

    conv2d_postproc #(.SHIFT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    conv2d_postproc #(.SHIFT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Expected-output queue and output monitor (samples on negedge)
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
        int         t;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] got_pix[$];
    int         got_cyc[$];
    int         n_out = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_err = 0;
    int         sof_cyc = -1;
    logic       last_eol = 1'b0, last_eof = 1'b0;

    task automatic monitor_sample();
        exp_t e;
        if (bus.valid_out === 1'b1) begin
            n_out++;
            got_pix.push_back(bus.pixel_out);
            got_cyc.push_back(cyc);
            if (bus.sof_out) begin
                n_sof++;
                sof_cyc = cyc;
            end
            if (bus.eol_out) n_eol++;
            if (bus.eof_out) n_eof++;
            last_eol = bus.eol_out;
            last_eof = bus.eof_out;
            if (exp_q.size() == 0) begin
                n_err++;
            end else begin
                e = exp_q.pop_front();
                if (bus.pixel_out !== e.pix || bus.sof_out !== e.sof ||
                    bus.eol_out !== e.eol || bus.eof_out !== e.eof || cyc != e.t)
                    n_err++;
            end
        end else if (bus.sof_out !== 1'b0 || bus.eol_out !== 1'b0 || bus.eof_out !== 1'b0) begin
            n_err++;
        end
        // Samples still in the pipeline are lost when reset hits.
        if (rst_n === 1'b0) exp_q.delete();
    endtask

    initial forever begin
        @(negedge clk);
        monitor_sample();
    end

    // ------------------------------------------------------------------
    // Stimulus with a raster model of the input stream
    // ------------------------------------------------------------------
    int m_col = 0;
    int m_row = 0;
    int last_t = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid_in = 1'b0;
        bus.frame_start = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [11:0] pix, input logic fs, input logic [7:0] exp_pix);
        int   c;
        int   r;
        exp_t e;
        c = fs ? 0 : m_col;
        r = fs ? 0 : m_row;
        bus.valid_in    = 1'b1;
        bus.pixel_in    = pix;
        bus.frame_start = fs;
        last_t = cyc;
        if (c >= KS - 1) begin
            e.pix = exp_pix;
            e.sof = (r == 0) && (c == KS - 1);
            e.eol = (c == IMG_W - 1);
            e.eof = (c == IMG_W - 1) && (r == N_ROWS - 1);
            e.t   = cyc + 2;
            exp_q.push_back(e);
        end
        tick();
        bus.valid_in    = 1'b0;
        bus.frame_start = 1'b0;
        if (c == IMG_W - 1) begin
            c = 0;
            r = (r == N_ROWS - 1) ? 0 : r + 1;
        end else begin
            c = c + 1;
        end
        m_col = c;
        m_row = r;
    endtask

    task automatic send0(input logic [11:0] pix);
        bus0.valid_in = 1'b1;
        bus0.pixel_in = pix;
        tick();
        bus0.valid_in = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    int b_out, b_sof, b_eol, b_eof, b_err, t3, t_sof;
    logic [11:0] rp;
    rsat_t       rs;

    initial begin
        rst_n = 1'b0;
        bus.valid_in = 1'b0;  bus.pixel_in = '0;  bus.frame_start = 1'b0;
        bus0.valid_in = 1'b0; bus0.pixel_in = '0; bus0.frame_start = 1'b0;
        tick();
        tick();
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_pixel_out", bus.pixel_out, 0);
        check("rst_markers", {bus.sof_out, bus.eol_out, bus.eof_out}, 0);
        check("rst_sat_count", bus.sat_count, 0);
        rst_n = 1'b1;
        idle(2);

        // Full frame, constant 240 -> (240+8)>>4 = 15
        b_out = n_out; b_sof = n_sof; b_eol = n_eol; b_eof = n_eof; b_err = n_err;
        t3 = 0;
        for (int k = 0; k < N_ROWS * IMG_W; k++) begin
            send(12'd240, 1'b0, 8'd15);
            if (k == 2) t3 = last_t;
        end
        idle(4);
        check("frame_outputs", n_out - b_out, 3844);
        check("frame_sof", n_sof - b_sof, 1);
        check("frame_eol", n_eol - b_eol, 62);
        check("frame_eof", n_eof - b_eof, 1);
        check("frame_stream_errs", n_err - b_err, 0);
        check("first_latency", got_cyc[b_out] - t3, 2);
        check("frame_first_pix", got_pix[b_out], 15);
        check("frame_last_pix", got_pix[n_out - 1], 15);
        check("frame_sat_count", bus.sat_count, 0);

        // Rounding boundary and saturation
        b_out = n_out; b_sof = n_sof; b_err = n_err;
        send(12'd0,    1'b1, 8'd0);
        send(12'd0,    1'b0, 8'd0);
        send(12'd23,   1'b0, 8'd1);
        send(12'd24,   1'b0, 8'd2);
        send(12'd4095, 1'b0, 8'd255);
        send(12'd4088, 1'b0, 8'd255);
        idle(4);
        check("round_23", got_pix[b_out], 1);
        check("round_24", got_pix[b_out + 1], 2);
        check("sat_4095", got_pix[b_out + 2], 255);
        check("sat_4088", got_pix[b_out + 3], 255);
        check("round_outputs", n_out - b_out, 4);
        check("round_sof", n_sof - b_sof, 1);
        check("round_stream_errs", n_err - b_err, 0);
`ifdef CONV_POSTPROC_SAT_STATS_EN
        check("sat_count_two", bus.sat_count, 2);
`else
        check("sat_count_tied", bus.sat_count, 0);
`endif
        check("pixel_hold", bus.pixel_out, 255);

        // Markers over a frame with ~60% valid, resync by frame_start alone
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        m_col = 0;
        m_row = 0;
        b_out = n_out; b_sof = n_sof; b_eol = n_eol; b_eof = n_eof; b_err = n_err;
        for (int k = 0; k < N_ROWS * IMG_W; k++) begin
            if ($urandom_range(0, 9) < 4) idle($urandom_range(1, 2));
            rp = 12'($urandom_range(0, 4095));
            rs = round_shift_sat(rp, 4);
            send(rp, 1'b0, rs.pix);
        end
        idle(4);
        check("bub_outputs", n_out - b_out, 3844);
        check("bub_sof", n_sof - b_sof, 1);
        check("bub_eol", n_eol - b_eol, 62);
        check("bub_eof", n_eof - b_eof, 1);
        check("bub_eof_with_last_eol", {last_eol, last_eof}, 2'b11);
        check("bub_stream_errs", n_err - b_err, 0);

        // frame_start with valid at row 5, col 30
        b_sof = n_sof; b_err = n_err;
        send(12'd240, 1'b1, 8'd15);
        for (int k = 1; k < 5 * IMG_W + 30; k++) send(12'd240, 1'b0, 8'd15);
        check("model_at_r5c30", m_row * IMG_W + m_col, 5 * IMG_W + 30);
        send(12'd240, 1'b1, 8'd15);
        send(12'd240, 1'b0, 8'd15);
        send(12'd240, 1'b0, 8'd15);
        t_sof = last_t;
        idle(4);
        check("resync_sof_count", n_sof - b_sof, 2);
        check("resync_sof_cycle", sof_cyc - t_sof, 2);
        check("resync_stream_errs", n_err - b_err, 0);

        // One-cycle reset mid-row with samples in flight
        b_err = n_err;
        send(12'd240, 1'b1, 8'd15);
        for (int k = 1; k < 10; k++) send(12'd240, 1'b0, 8'd15);
        rst_n = 1'b0;
        tick();
        check("midrst_valid_out", bus.valid_out, 0);
        check("midrst_pixel_out", bus.pixel_out, 0);
        rst_n = 1'b1;
        m_col = 0;
        m_row = 0;
        b_out = n_out; b_sof = n_sof;
        for (int k = 0; k < 4; k++) send(12'd240, 1'b0, 8'd15);
        idle(4);
        check("midrst_outputs", n_out - b_out, 2);
        check("midrst_sof", n_sof - b_sof, 1);
        check("midrst_stream_errs", n_err - b_err, 0);

        // SHIFT=0 instance: pass-through and clamp
        send0(12'd0);
        send0(12'd0);
        send0(12'd200);
        tick();
        check("s0_valid", bus0.valid_out, 1);
        check("s0_pix_200", bus0.pixel_out, 200);
        check("s0_sof", bus0.sof_out, 1);
        send0(12'd4095);
        tick();
        check("s0_pix_4095", bus0.pixel_out, 255);
        tick();
        check("s0_idle_valid", bus0.valid_out, 0);
        check("s0_idle_hold", bus0.pixel_out, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
